lcd_bus_responder: RTL and testbench

- Synthesizable responder for the HD44780-style 8-bit LCD bus (EN/RS/RW/DATA). It is the device end of the bus that our LCD controller drives.
- Decodes command and data transactions and keeps a 2x16 display RAM, the address counter (AC) and mode flags.
- Answers busy-flag and data reads on the shared data bus.
- Used as the on-chip/bench LCD stand-in and exposes a debug read port so checkers can inspect the displayed text.

---
 rtl/lcd_bus_responder.sv | 198 +++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// HD44780-style 8-bit LCD bus responder with a 2x16 display RAM and a debug read port.
// Optional protocol checker enabled by defining LCD_PROTOCOL_CHECK_EN.
module lcd_bus_responder #(
  parameter int BUSY_CYCLES       = 16,
  parameter int CLEAR_BUSY_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  inout  wire  [7:0] lcd_data,
  input  logic [4:0] dbg_addr,
  output logic [7:0] dbg_char,
  output logic [6:0] addr_counter,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       func_8bit,
  output logic       func_2line,
  output logic       cmd_strobe,
  output logic       data_strobe,
  output logic       protocol_err
);

  localparam int MAXB = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : BUSY_CYCLES;
  localparam int CW   = $clog2(MAXB + 1);

  logic          r_en_q;
  logic [7:0]    r_ram [32];
  logic [CW-1:0] r_busy_cnt;
  logic          r_fill_act;
  logic [4:0]    r_fill_idx;
  logic          r_pend_vld;
  logic [4:0]    r_pend_idx;
  logic [7:0]    r_pend_data;

  logic       w_done;
  logic       w_vis;
  logic [4:0] w_cell;
  logic [7:0] w_rd_byte;
  logic [7:0] w_bus_out;
  logic [6:0] w_ac_next;

  function automatic logic [6:0] ac_inc(input logic [6:0] a);
    case (a)
      7'h27:   return 7'h40;
      7'h67:   return 7'h00;
      default: return a + 7'd1;
    endcase
  endfunction

  function automatic logic [6:0] ac_dec(input logic [6:0] a);
    case (a)
      7'h00:   return 7'h67;
      7'h40:   return 7'h27;
      default: return a - 7'd1;
    endcase
  endfunction

  assign w_done    = r_en_q & ~lcd_en;
  assign busy      = (r_busy_cnt != '0);
  // Line 1 lives at 0x00-0x0F, line 2 at 0x40-0x4F; AC[6] selects the upper half of the RAM.
  assign w_vis     = (addr_counter[6:4] == 3'b000) | (addr_counter[6:4] == 3'b100);
  assign w_cell    = {addr_counter[6], addr_counter[3:0]};
  assign w_rd_byte = w_vis ? r_ram[w_cell] : 8'h20;
  assign w_bus_out = lcd_rs ? w_rd_byte : {busy, addr_counter};
  assign w_ac_next = entry_inc ? ac_inc(addr_counter) : ac_dec(addr_counter);
  assign lcd_data  = lcd_rw ? w_bus_out : 8'hzz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en_q       <= 1'b0;
      for (int i = 0; i < 32; i++) r_ram[i] <= 8'h20;
      r_busy_cnt   <= '0;
      r_fill_act   <= 1'b0;
      r_fill_idx   <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_data  <= 8'h20;
      addr_counter <= '0;
      display_on   <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      entry_inc    <= 1'b1;
      func_8bit    <= 1'b1;
      func_2line   <= 1'b0;
      cmd_strobe   <= 1'b0;
      data_strobe  <= 1'b0;
      dbg_char     <= 8'h20;
    end else begin
      r_en_q      <= lcd_en;
      cmd_strobe  <= 1'b0;
      data_strobe <= 1'b0;
      dbg_char    <= r_ram[dbg_addr];
      if (busy) r_busy_cnt <= r_busy_cnt - CW'(1);

      // Clear fill owns the RAM port; a data write landing during the fill waits until it ends.
      if (r_fill_act) begin
        r_ram[r_fill_idx] <= 8'h20;
        r_fill_idx        <= r_fill_idx + 5'd1;
        if (r_fill_idx == 5'd31) r_fill_act <= 1'b0;
      end else if (r_pend_vld) begin
        r_ram[r_pend_idx] <= r_pend_data;
        r_pend_vld        <= 1'b0;
      end

      if (w_done) begin
        case ({lcd_rs, lcd_rw})
          2'b00: begin
            cmd_strobe <= 1'b1;
            r_busy_cnt <= CW'(BUSY_CYCLES);
            casez (lcd_data)
              8'b1???????: addr_counter <= lcd_data[6:0];
              8'b01??????: ;
              8'b001?????: begin
                func_8bit  <= lcd_data[4];
                func_2line <= lcd_data[3];
              end
              8'b0001????: ;
              8'b00001???: begin
                display_on <= lcd_data[2];
                cursor_on  <= lcd_data[1];
                blink_on   <= lcd_data[0];
              end
              8'b000001??: entry_inc <= lcd_data[1];
              8'b0000001?: begin
                addr_counter <= '0;
                r_busy_cnt   <= CW'(CLEAR_BUSY_CYCLES);
              end
              8'b00000001: begin
                addr_counter <= '0;
                entry_inc    <= 1'b1;
                r_busy_cnt   <= CW'(CLEAR_BUSY_CYCLES);
                r_fill_act   <= 1'b1;
                r_fill_idx   <= '0;
                r_pend_vld   <= 1'b0;
              end
              default: ;
            endcase
          end
          2'b10: begin
            data_strobe  <= 1'b1;
            r_busy_cnt   <= CW'(BUSY_CYCLES);
            addr_counter <= w_ac_next;
            if (w_vis) begin
              if (r_fill_act) begin
                r_pend_vld  <= 1'b1;
                r_pend_idx  <= w_cell;
                r_pend_data <= lcd_data;
              end else begin
                r_ram[w_cell] <= lcd_data;
              end
            end
          end
          2'b11:   addr_counter <= w_ac_next;
          default: ;
        endcase
      end
    end
  end

`ifdef LCD_PROTOCOL_CHECK_EN
  logic r_rs_q;
  logic r_rw_q;
  logic r_seen_on;
  logic r_perr;
  logic w_disp_on_cmd;
  logic w_busy_wr;
  logic w_ctl_chg;

  assign w_disp_on_cmd = w_done & ~lcd_rs & ~lcd_rw & (lcd_data[7:3] == 5'b00001) & lcd_data[2];
  // Busy writes only count once the controller has finished init (first display-on).
  assign w_busy_wr     = w_done & ~lcd_rw & busy & r_seen_on;
  assign w_ctl_chg     = r_en_q & lcd_en & ((lcd_rs ^ r_rs_q) | (lcd_rw ^ r_rw_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rs_q    <= 1'b0;
      r_rw_q    <= 1'b0;
      r_seen_on <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_rs_q <= lcd_rs;
      r_rw_q <= lcd_rw;
      if (w_disp_on_cmd) r_seen_on <= 1'b1;
      if (w_busy_wr | w_ctl_chg) r_perr <= 1'b1;
    end
  end

  assign protocol_err = r_perr;
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed self-checking bench for lcd_bus_responder: init sequence, text writes,
// AC wrap boundaries, status/data reads and the protocol error flag.
module tb_lcd_bus_responder;

  logic       clk;
  logic       rst_n;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] tb_dout;
  wire  [7:0] lcd_data;
  logic [4:0] dbg_addr;
  logic [7:0] dbg_char;
  logic [6:0] addr_counter;
  logic       busy, display_on, cursor_on, blink_on, entry_inc;
  logic       func_8bit, func_2line, cmd_strobe, data_strobe, protocol_err;

  int checks = 0;
  int errors = 0;
  int ds_cnt = 0;
  logic [7:0] exp_ram [32];

  assign lcd_data = lcd_rw ? 8'hzz : tb_dout;

  lcd_bus_responder #(.BUSY_CYCLES(16), .CLEAR_BUSY_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .dbg_addr(dbg_addr), .dbg_char(dbg_char),
    .addr_counter(addr_counter), .busy(busy), .display_on(display_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .entry_inc(entry_inc),
    .func_8bit(func_8bit), .func_2line(func_2line), .cmd_strobe(cmd_strobe),
    .data_strobe(data_strobe), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (data_strobe) ds_cnt <= ds_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic bus_wr(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b0; tb_dout = d; lcd_en = 1'b1;
    @(negedge clk);
    lcd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_rd(input logic rs, output logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
    @(negedge clk);
    d = lcd_data;
    lcd_en = 1'b0;
    @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_rdy();
    logic [7:0] st;
    int n;
    n = 0;
    st = 8'h80;
    while (st[7] && n < 100) begin
      bus_rd(1'b0, st);
      n++;
    end
    chk("rdy", {31'd0, st[7]}, 32'd0);
  endtask

  task automatic check_ram(input string tag);
    logic [7:0] c;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      dbg_addr = 5'(i);
      @(negedge clk);
      c = dbg_char;
      chk($sformatf("%s_cell%0d", tag, i), {24'd0, c}, {24'd0, exp_ram[i]});
    end
  endtask

  initial begin
    string      s;
    logic [7:0] st;
    int         bc;
    int         ds0;

    rst_n = 1'b0; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; tb_dout = 8'h00; dbg_addr = '0;
    for (int i = 0; i < 32; i++) exp_ram[i] = 8'h20;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ac", {25'd0, addr_counter}, 0);
    chk("rst_disp", {29'd0, display_on, cursor_on, blink_on}, 0);
    chk("rst_entry", {31'd0, entry_inc}, 1);
    chk("rst_func", {30'd0, func_8bit, func_2line}, 32'b10);
    chk("rst_perr", {31'd0, protocol_err}, 0);
    bus_rd(1'b0, st);
    chk("rst_status", {24'd0, st}, 32'h00);
    check_ram("rst");

    for (int k = 0; k < 5; k++) begin
      bus_wr(1'b0, 8'h38);
      repeat (20) @(negedge clk);
    end
    chk("init_2line", {31'd0, func_2line}, 1);
    bus_wr(1'b0, 8'h0E);
    wait_rdy();
    bus_wr(1'b0, 8'h01);
    bc = 0;
    while (busy && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    chk("clear_busy_len", bc, 64);
    bus_wr(1'b0, 8'h06);
    wait_rdy();
    chk("init_func", {30'd0, func_8bit, func_2line}, 32'b11);
    chk("init_disp", {29'd0, display_on, cursor_on, blink_on}, 32'b110);
    chk("init_entry", {31'd0, entry_inc}, 1);
    chk("init_ac", {25'd0, addr_counter}, 0);
    check_ram("clr");

    s = "Enter Combo     ";
    ds0 = ds_cnt;
    for (int i = 0; i < 16; i++) begin
      bus_wr(1'b1, s[i]);
      exp_ram[i] = s[i];
      wait_rdy();
    end
    chk("text_ac", {25'd0, addr_counter}, 32'h10);
    bus_wr(1'b0, 8'h02);
    wait_rdy();
    chk("home_ac", {25'd0, addr_counter}, 0);
    chk("data_strobes", ds_cnt - ds0, 16);
    check_ram("text");

    bus_wr(1'b0, 8'hC0);
    wait_rdy();
    bus_wr(1'b1, 8'h31); wait_rdy();
    bus_wr(1'b1, 8'h32); wait_rdy();
    bus_wr(1'b1, 8'h33);
    exp_ram[16] = 8'h31; exp_ram[17] = 8'h32; exp_ram[18] = 8'h33;
    bus_rd(1'b0, st);
    chk("status_busy", {24'd0, st}, 32'hC3);
    wait_rdy();
    bus_rd(1'b0, st);
    chk("status_idle", {24'd0, st}, 32'h43);
    chk("line2_ac", {25'd0, addr_counter}, 32'h43);
    check_ram("line2");

    bus_wr(1'b0, 8'hA7); wait_rdy();
    bus_wr(1'b1, 8'h58); wait_rdy();
    chk("wrap_27", {25'd0, addr_counter}, 32'h40);
    bus_wr(1'b0, 8'hE7); wait_rdy();
    bus_wr(1'b1, 8'h59); wait_rdy();
    chk("wrap_67", {25'd0, addr_counter}, 32'h00);
    check_ram("hidden");
    bus_wr(1'b0, 8'h04); wait_rdy();
    chk("entry_dec", {31'd0, entry_inc}, 0);
    bus_wr(1'b0, 8'hC0); wait_rdy();
    bus_wr(1'b1, 8'h5A); wait_rdy();
    exp_ram[16] = 8'h5A;
    chk("dec_40", {25'd0, addr_counter}, 32'h27);
    check_ram("dec");

    bus_wr(1'b0, 8'h80); wait_rdy();
    bus_rd(1'b1, st);
    chk("rd_cell0", {24'd0, st}, 32'h45);
    chk("dec_00", {25'd0, addr_counter}, 32'h67);
    bus_wr(1'b0, 8'h06); wait_rdy();
    bus_wr(1'b0, 8'hC1); wait_rdy();
    bus_rd(1'b1, st);
    chk("rd_cell17", {24'd0, st}, 32'h32);
    chk("rd_inc_ac", {25'd0, addr_counter}, 32'h42);
    bus_wr(1'b0, 8'hA0); wait_rdy();
    bus_rd(1'b1, st);
    chk("rd_hidden", {24'd0, st}, 32'h20);
    chk("rd_hidden_ac", {25'd0, addr_counter}, 32'h21);

    bus_wr(1'b0, 8'h0D); wait_rdy();
    chk("disp_0d", {29'd0, display_on, cursor_on, blink_on}, 32'b101);
    chk("perr_clean", {31'd0, protocol_err}, 0);

    bus_wr(1'b1, 8'h41);
    bus_wr(1'b1, 8'h41);
    repeat (30) @(negedge clk);
`ifdef LCD_PROTOCOL_CHECK_EN
    chk("perr_set", {31'd0, protocol_err}, 1);
`else
    chk("perr_off", {31'd0, protocol_err}, 0);
`endif

    bus_wr(1'b0, 8'h01);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2_perr", {31'd0, protocol_err}, 0);
    chk("rst2_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 32; i++) exp_ram[i] = 8'h20;
    check_ram("rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
